// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Multi-cycle integer multiply/divide unit for the MIPS arithmetic elements.
// Executes MULTU, MULT, DIVU and DIV with a radix-2 iterative datapath
// (shift-add for multiply, restoring subtract for divide). Results land in
// the architectural HI/LO registers, which the ALU result mux reads for
// MFHI/MFLO.
//
// Timing: the start edge latches the operands, WIDTH edges iterate in RUN,
// and one more edge in DONE applies the sign fix-up and writes HI/LO while
// raising done for one cycle. A division by zero skips RUN entirely.
//
// Optional feature: define MULT_DIV_HILO_WRITE_EN to add MTHI/MTLO write
// ports (hi_we, lo_we, wdata). Writes are honoured only in IDLE when no
// start is being accepted.
//
// Ports:
//   clock        in   system clock, all state updates on posedge
//   reset        in   synchronous, active-low reset
//   start        in   launch an operation (sampled only in IDLE)
//   op           in   00=MULTU 01=MULT 10=DIVU 11=DIV
//   input_a      in   multiplicand / dividend
//   input_b      in   multiplier / divisor
//   hi_we        in   (MULT_DIV_HILO_WRITE_EN only) write wdata into HI
//   lo_we        in   (MULT_DIV_HILO_WRITE_EN only) write wdata into LO
//   wdata        in   (MULT_DIV_HILO_WRITE_EN only) MTHI/MTLO data
//   busy         out  high while iterating
//   done         out  one-cycle pulse, HI/LO hold new results that cycle
//   div_by_zero  out  sticky flag, set by a divide with a zero divisor
//   hi           out  HI register (product upper half / remainder)
//   lo           out  LO register (product lower half / quotient)
// ---------------------------------------------------------------------------
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] input_a,
   input  logic [WIDTH-1:0] input_b,
`ifdef MULT_DIV_HILO_WRITE_EN
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
`endif
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t               state_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   accStep_d;
   logic [WIDTH-1:0]     operand_q;
   logic [CW-1:0]        count_q;
   logic                 isDiv_q;
   logic                 negLo_q;
   logic                 negHi_q;
   logic                 dbzPend_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 dbz_q;
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;
   logic [WIDTH-1:0]     hi_d;
   logic [WIDTH-1:0]     lo_d;

   logic                 negA;
   logic                 negB;
   logic [WIDTH-1:0]     magA;
   logic [WIDTH-1:0]     magB;
   logic                 divZero;

   // Operand preparation for the start edge. Signed ops iterate on
   // magnitudes; the most negative value is its own unsigned magnitude.
   always_comb begin
      negA    = op[0] & input_a[WIDTH-1];
      negB    = op[0] & input_b[WIDTH-1];
      magA    = negA ? -input_a : input_a;
      magB    = negB ? -input_b : input_b;
      divZero = op[1] & (input_b == '0);
   end

   logic [WIDTH:0]       mulSum;
   logic [2*WIDTH-1:0]   mulNext;
   logic [WIDTH:0]       divTop;
   logic                 divFits;
   logic [WIDTH-1:0]     divRem;
   logic [2*WIDTH-1:0]   divNext;

   // One radix-2 iteration. The accumulator holds {upper, lower}:
   // multiply keeps {partial product, remaining multiplier bits} and shifts
   // right, keeping the add carry as the new top bit. Divide keeps
   // {partial remainder, dividend/quotient bits} and shifts left; the
   // quotient bit enters at the bottom as the dividend bits leave the top.
   always_comb begin
      mulSum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, operand_q};
      mulNext   = acc_q[0] ? {mulSum, acc_q[WIDTH-1:1]}
                           : {1'b0, acc_q[2*WIDTH-1:1]};
      divTop    = acc_q[2*WIDTH-1:WIDTH-1];
      divFits   = divTop >= {1'b0, operand_q};
      divRem    = divFits ? (divTop[WIDTH-1:0] - operand_q) : divTop[WIDTH-1:0];
      divNext   = {divRem, acc_q[WIDTH-2:0], divFits};
      accStep_d = isDiv_q ? divNext : mulNext;
   end

   // Sign fix-up and result selection for the DONE write. A zero-divisor
   // divide parked the raw dividend in the lower half of the accumulator.
   always_comb begin
      hi_d = acc_q[2*WIDTH-1:WIDTH];
      lo_d = acc_q[WIDTH-1:0];
      if (dbzPend_q) begin
         hi_d = acc_q[WIDTH-1:0];
         lo_d = '1;
      end else if (isDiv_q) begin
         hi_d = negHi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
         lo_d = negLo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end else if (negLo_q) begin
         {hi_d, lo_d} = -acc_q;
      end
   end

   // Control FSM with registered outputs. Reset discards any operation in
   // flight. The remainder sign follows the dividend; every other result
   // sign is the XOR of the operand signs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         operand_q <= '0;
         count_q   <= '0;
         isDiv_q   <= 1'b0;
         negLo_q   <= 1'b0;
         negHi_q   <= 1'b0;
         dbzPend_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  isDiv_q <= op[1];
                  count_q <= '0;
                  dbz_q   <= 1'b0;
                  negLo_q <= negA ^ negB;
                  negHi_q <= op[1] ? negA : (negA ^ negB);
                  if (divZero) begin
                     acc_q     <= {{WIDTH{1'b0}}, input_a};
                     dbzPend_q <= 1'b1;
                     state_q   <= DONE;
                  end else begin
                     operand_q <= op[1] ? magB : magA;
                     acc_q     <= {{WIDTH{1'b0}}, (op[1] ? magA : magB)};
                     dbzPend_q <= 1'b0;
                     busy_q    <= 1'b1;
                     state_q   <= RUN;
                  end
               end
`ifdef MULT_DIV_HILO_WRITE_EN
               else begin
                  if (hi_we) hi_q <= wdata;
                  if (lo_we) lo_q <= wdata;
               end
`endif
            end
            RUN: begin
               acc_q   <= accStep_d;
               count_q <= count_q + CW'(1);
               if (count_q == CW'(WIDTH - 1)) begin
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               done_q  <= 1'b1;
               if (dbzPend_q) dbz_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//
// Scoreboard bench for mult_div_unit. The driver pushes the expected HI/LO,
// div_by_zero flag and completion cycle of every launched operation into a
// queue; an independent monitor pops and compares whenever done is seen.
// Expected results come from plain 64-bit arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          cycle;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] input_a;
   logic [31:0] input_b;
`ifdef MULT_DIV_HILO_WRITE_EN
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
`endif
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int   compared   = 0;
   int   mismatched = 0;
   int   cycleCount = 0;
   exp_t sb[$];
   exp_t monE;
   logic prevDone = 1'b0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .input_a    (input_a),
      .input_b    (input_b),
`ifdef MULT_DIV_HILO_WRITE_EN
      .hi_we      (hi_we),
      .lo_we      (lo_we),
      .wdata      (wdata),
`endif
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .hi         (hi),
      .lo         (lo)
   );

   // Free-running clock and an edge counter used to time completions.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: architectural results from plain arithmetic.
   function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                  input logic [31:0] b, input int launch);
      exp_t        e;
      longint      sa;
      longint      sbv;
      longint      p;
      longint      q;
      longint      r;
      logic [63:0] up;
      sa  = $signed(a);
      sbv = $signed(b);
      e.dbz   = 1'b0;
      e.cycle = launch + 34;
      e.hi    = '0;
      e.lo    = '0;
      if (o[1] && b == 32'd0) begin
         e.hi    = a;
         e.lo    = 32'hFFFF_FFFF;
         e.dbz   = 1'b1;
         e.cycle = launch + 2;
      end else begin
         case (o)
            2'd0: begin
               up = {32'd0, a} * {32'd0, b};
               e.hi = up[63:32];
               e.lo = up[31:0];
            end
            2'd1: begin
               p  = sa * sbv;
               up = p;
               e.hi = up[63:32];
               e.lo = up[31:0];
            end
            2'd2: begin
               e.hi = a % b;
               e.lo = a / b;
            end
            default: begin
               q = sa / sbv;
               r = sa % sbv;
               e.hi = r[31:0];
               e.lo = q[31:0];
            end
         endcase
      end
      return e;
   endfunction

   // Monitor: compare each completed operation against the scoreboard.
   always @(negedge clock) begin
      if (reset === 1'b1 && done === 1'b1) begin
         if (prevDone) checkOutput("donePulseWidth", 64'd1, 64'd0);
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpectedDone: got done=1 expected no pending op");
         end else begin
            monE = sb.pop_front();
            checkOutput("hi", {32'd0, hi}, {32'd0, monE.hi});
            checkOutput("lo", {32'd0, lo}, {32'd0, monE.lo});
            checkOutput("divByZero", {63'd0, div_by_zero}, {63'd0, monE.dbz});
            checkOutput("doneCycle", 64'(cycleCount), 64'(monE.cycle));
         end
      end
      prevDone <= (done === 1'b1);
   end

   // Launch an operation at the current negedge; returns at the negedge
   // after the accepting edge.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input bit hold,
                                input bit push);
      start   = 1'b1;
      op      = o;
      input_a = a;
      input_b = b;
      if (push) sb.push_back(model(o, a, b, cycleCount));
      @(posedge clock);
      @(negedge clock);
      checkOutput("dbzClearOnStart", {63'd0, div_by_zero}, 64'd0);
      if (!hold) start = 1'b0;
   endtask

   // Wait (bounded) for done, counting busy cycles; optionally pulse a
   // stray start with different operands at RUN cycle ignoreAt+1.
   task automatic waitDone(input int expBusy, input int ignoreAt);
      int busyCnt = 0;
      int k       = 0;
      bit seen    = 0;
      while (k < 60 && !seen) begin
         if (done === 1'b1) begin
            seen = 1;
         end else begin
            if (busy === 1'b1) busyCnt++;
            if (ignoreAt > 0 && k == ignoreAt) begin
               start   = 1'b1;
               op      = 2'($urandom_range(0, 3));
               input_a = $urandom;
               input_b = $urandom;
            end else if (ignoreAt > 0 && k == ignoreAt + 1) begin
               start = 1'b0;
            end
            k++;
            @(negedge clock);
         end
      end
      if (!seen) checkOutput("doneTimeout", 64'd0, 64'd1);
      checkOutput("busyCycles", 64'(busyCnt), 64'(expBusy));
   endtask

   task automatic runOp(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit hold,
                        input int ignoreAt);
      int expBusy;
      expBusy = (o[1] && b == 32'd0) ? 0 : 32;
      applyStimulus(o, a, b, hold, 1'b1);
      waitDone(expBusy, ignoreAt);
   endtask

   initial begin
      bit          sawDone;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  ro;
      int          sel;
      start   = 1'b0;
      op      = 2'd0;
      input_a = '0;
      input_b = '0;
      reset   = 1'b0;
`ifdef MULT_DIV_HILO_WRITE_EN
      hi_we = 1'b0;
      lo_we = 1'b0;
      wdata = '0;
`endif
      repeat (2) @(negedge clock);
      checkOutput("resetBusy", {63'd0, busy}, 64'd0);
      checkOutput("resetDone", {63'd0, done}, 64'd0);
      checkOutput("resetDbz", {63'd0, div_by_zero}, 64'd0);
      checkOutput("resetHi", {32'd0, hi}, 64'd0);
      checkOutput("resetLo", {32'd0, lo}, 64'd0);
      reset = 1'b1;
      @(negedge clock);

      // Directed cases.
      runOp(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      runOp(2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0);
      runOp(2'd1, 32'h0000_0000, 32'h8000_0000, 0, 0);
      runOp(2'd2, 32'd100, 32'd7, 0, 0);
      runOp(2'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
      runOp(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      runOp(2'd2, 32'd5, 32'd0, 0, 0);
      repeat (3) @(negedge clock);
      checkOutput("dbzSticky", {63'd0, div_by_zero}, 64'd1);
      checkOutput("dbzHoldHi", {32'd0, hi}, 64'd5);
      checkOutput("dbzHoldLo", {32'd0, lo}, 64'hFFFF_FFFF);
      runOp(2'd2, 32'd81, 32'd9, 0, 0);

      // Start held across DONE->IDLE launches the next op immediately.
      runOp(2'd1, 32'd12345, 32'hFFFF_FF00, 1, 0);
      runOp(2'd3, 32'hFFFF_0000, 32'd77, 0, 0);

      // Randomised operations with some boundary-biased operands.
      for (int i = 0; i < 40; i++) begin
         ro  = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 9);
         ra  = $urandom;
         rb  = $urandom;
         if (sel == 0) rb = 32'd0;
         else if (sel == 1) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end else if (sel == 2) begin
            ra = 32'($urandom_range(0, 300)) - 32'd150;
            rb = 32'($urandom_range(1, 20));
         end
         runOp(ro, ra, rb, ($urandom_range(0, 3) == 0), 0);
      end
      start = 1'b0;
      @(negedge clock);

      // Stray start during RUN is ignored.
      runOp(2'd0, 32'd1234, 32'd5678, 0, 4);
      @(negedge clock);

      // Reset in the middle of RUN discards the operation.
      applyStimulus(2'd0, 32'hDEAD_BEEF, 32'h0000_1234, 0, 0);
      repeat (9) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("midResetBusy", {63'd0, busy}, 64'd0);
      checkOutput("midResetDone", {63'd0, done}, 64'd0);
      checkOutput("midResetHi", {32'd0, hi}, 64'd0);
      checkOutput("midResetLo", {32'd0, lo}, 64'd0);
      reset   = 1'b1;
      sawDone = 0;
      repeat (40) begin
         @(negedge clock);
         if (done === 1'b1) sawDone = 1;
      end
      checkOutput("noDoneAfterReset", {63'd0, sawDone}, 64'd0);

`ifdef MULT_DIV_HILO_WRITE_EN
      // MTHI/MTLO writes in IDLE, ignored while RUN.
      hi_we = 1'b1;
      wdata = 32'h1234_5678;
      @(negedge clock);
      hi_we = 1'b0;
      checkOutput("mthiIdle", {32'd0, hi}, 64'h1234_5678);
      lo_we = 1'b1;
      wdata = 32'h0BAD_F00D;
      @(negedge clock);
      lo_we = 1'b0;
      checkOutput("mtloIdle", {32'd0, lo}, 64'h0BAD_F00D);
      checkOutput("mtloKeepsHi", {32'd0, hi}, 64'h1234_5678);
      applyStimulus(2'd0, 32'd3, 32'd5, 0, 1);
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hCAFE_CAFE;
      repeat (2) @(negedge clock);
      hi_we = 1'b0;
      lo_we = 1'b0;
      checkOutput("mthiInRun", {32'd0, hi}, 64'h1234_5678);
      checkOutput("mtloInRun", {32'd0, lo}, 64'h0BAD_F00D);
      waitDone(30, 0);
`endif

      repeat (3) @(negedge clock);
      checkOutput("pendingResults", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle integer multiply/divide unit for the MIPS arithmetic elements. It executes MULT, MULTU, DIV and DIVU as a radix-2 iterative shift-add / restoring-subtract datapath and holds the results in architectural HI/LO registers. It sits downstream of the register-file read stage, alongside the combinational ALU elements. The ALU's result mux consumes HI/LO for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-low reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV
input_a  input  WIDTH  multiplicand / dividend
input_b  input  WIDTH  multiplier / divisor
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; HI/LO updated this cycle
div_by_zero  output  1  sticky until next accepted start; set by DIV/DIVU with input_b=0
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Interface: reset is synchronous, active-low; clock is clock.
- reset=0 at posedge:
  - state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - Overrides everything, including mid-RUN; the in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Latch op and operands.
  - Signed ops (MULT/DIV) take magnitudes and record the result signs.
  - Iteration counter cleared.
  - Next state is RUN, except for a division by zero (see below).
- RUN, edges E1..E32: one iteration per edge.
  - Multiply: conditional add of the multiplicand magnitude, then shift right of the 2*WIDTH accumulator.
  - Divide: shift left, trial subtract, restore on borrow, set quotient bit.
  - busy=1 throughout RUN. At E32 the state moves to DONE.
- DONE:
  - At E33, sign fix-up is applied and written to hi/lo, and done=1 for exactly the cycle after E33.
  - DONE→IDLE at the next edge unconditionally.
  - Total latency is start edge to results-visible = 33 edges.
- Signed rules:
  - MULT: 64-bit product is negated if operand signs differ.
  - DIV: quotient is negated if signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (op[1]=1, input_b=0):
  - IDLE→DONE directly at E0 (RUN skipped).
  - At E1: lo=all ones, hi=input_a, div_by_zero=1, done=1 next cycle.
- Start handling:
  - start in RUN or DONE is ignored, with no queuing.
  - start held high across DONE→IDLE launches a new op at the first IDLE edge.
- hi/lo hold their values between operations and change only at done or reset.
- div_by_zero clears on the next accepted start.

Optional Feature:
Macro: MULT_DIV_HILO_WRITE_EN.
- Defined:
  - Adds ports hi_we (in, 1), lo_we (in, 1) and wdata (in, WIDTH) for MTHI/MTLO.
  - Writes take effect at a posedge only when state=IDLE and start=0; start has priority.
  - Writes are ignored in RUN and DONE.
  - hi_we and lo_we together write wdata to both registers.
- Undefined: the ports are absent and hi/lo are writable only by completed operations.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF → busy for 32 cycles, done pulses 33 edges after start, hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD(-3)*0x00000007 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0*0x80000000 → hi=lo=0.
- DIVU 100/7 → lo=14, hi=2; DIV 0xFFFFFFF9(-7)/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5/0 → done one cycle after start, busy never high, div_by_zero=1, lo=0xFFFFFFFF, hi=5; next valid start clears div_by_zero.
- start pulsed at RUN cycle 5 with different operands → ignored, original result delivered. Then reset=0 at RUN cycle 10 of the next op → at the next edge busy=0, done=0, hi=lo=0, state IDLE, with no done pulse afterwards.
- With MULT_DIV_HILO_WRITE_EN: hi_we=1, wdata=0x12345678 in IDLE → hi=0x12345678. The same write during RUN → hi unchanged until done.
